// File: rtl/m_pkg.sv
// m_pkg: shared state encoding and recurrence constants for the m-sequence checker.
package m_pkg;
  typedef enum logic [1:0] {FILL, ACQ, LOCKED} m_state_e;
  localparam logic [3:0] M_TAPS = 4'b1001;
  localparam int M_PERIOD = 15;
  function automatic logic m_predict(input logic [3:0] h);
    return ^(h & M_TAPS);
  endfunction
endpackage

// File: rtl/m_pred.sv
// m_pred: 4-bit history with next-bit prediction; shifts either received or predicted bits.
module m_pred
  import m_pkg::*;
(
  input  logic clk_mar,
  input  logic rst,
  input  logic shift,
  input  logic use_pred,
  input  logic bit_in,
  output logic p,
  output logic h_zero
);
  logic [3:0] h_q, h_d;
  assign p = m_predict(h_q);
  assign h_zero = h_q == 4'd0;
  always_comb h_d = shift ? {h_q[2:0], use_pred ? p : bit_in} : h_q;
  always_ff @(posedge clk_mar or posedge rst)
    if (rst) h_q <= 4'd0;
    else h_q <= h_d;
endmodule

// File: rtl/m_check.sv
// m_check: self-synchronising m-sequence checker with lock detection and windowed error counts.
module m_check
  import m_pkg::*;
#(
  parameter int WIN_LEN  = 1500,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_THR = 32
) (
  input  logic        clk_mar,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        lock,
  output logic        err_pulse,
  output logic [15:0] err_snap,
  output logic        win_done
);
  localparam int WB_W = $clog2(WIN_LEN + 1);
  m_state_e state_q, state_d;
  logic [1:0] fill_q, fill_d;
  logic [7:0] run_q, run_d;
  logic [WB_W-1:0] wbits_q, wbits_d;
  logic [15:0] werr_q, werr_d, werr_inc, snap_q, snap_d;
  logic lock_q, lock_d, err_q, err_d, win_q, win_d;
  logic p, h_zero, mis;
  m_pred u_pred (
    .clk_mar (clk_mar),
    .rst     (rst),
    .shift   (bit_valid),
    .use_pred(state_q == LOCKED),
    .bit_in  (bit_in),
    .p       (p),
    .h_zero  (h_zero)
  );
  assign mis = bit_in ^ p;
  assign werr_inc = (werr_q == 16'hFFFF) ? werr_q : werr_q + {15'd0, mis};
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    run_d   = run_q;
    wbits_d = wbits_q;
    werr_d  = werr_q;
    snap_d  = snap_q;
    err_d   = 1'b0;
    win_d   = 1'b0;
    if (bit_valid && state_q == FILL) begin
      fill_d  = fill_q + 2'd1;
      state_d = (fill_q == 2'd3) ? ACQ : FILL;
    end else if (bit_valid && state_q == ACQ) begin
      // an all-zero history predicts zeros forever, so it must never build a run
      run_d = (!mis && !h_zero) ? run_q + 8'd1 : 8'd0;
      if (run_d == 8'(LOCK_CNT)) begin
        state_d = LOCKED;
        wbits_d = '0;
        werr_d  = '0;
      end
    end else if (bit_valid && state_q == LOCKED) begin
      err_d   = mis;
      wbits_d = wbits_q + 1'b1;
      werr_d  = werr_inc;
      if (wbits_q == WB_W'(WIN_LEN - 1)) begin
        snap_d  = werr_inc;
        win_d   = 1'b1;
        wbits_d = '0;
        werr_d  = '0;
      end
      if (werr_inc == 16'(LOSS_THR)) begin
        state_d = ACQ;
        run_d   = 8'd0;
        wbits_d = '0;
        werr_d  = '0;
      end
    end
    lock_d = state_d == LOCKED;
  end
  always_ff @(posedge clk_mar or posedge rst)
    if (rst) begin
      state_q <= FILL;
      fill_q  <= 2'd0;
      run_q   <= 8'd0;
      wbits_q <= '0;
      werr_q  <= 16'd0;
      snap_q  <= 16'd0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      wbits_q <= wbits_d;
      werr_q  <= werr_d;
      snap_q  <= snap_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      win_q   <= win_d;
    end
  assign lock      = lock_q;
  assign err_pulse = err_q;
  assign err_snap  = snap_q;
  assign win_done  = win_q;
endmodule

// File: doc/m_check.md
# m_check

Receive-side checker for the 4-bit maximal-length m-sequence (period 15) produced by the transmit-side `M_array` generator. Predicts each received bit from the sequence recurrence, self-synchronises to the incoming stream, and declares lock. Counts bit errors over fixed measurement windows. Sits after the demodulator's bit slicer and feeds BER values to the status/display logic.

## Interface
Parameters:
- `WIN_LEN`, 1500: bits per measurement window (≥ 16).
- `LOCK_CNT`, 16: consecutive correct predictions required to lock (8..255).
- `LOSS_THR`, 32: errors within one window that force loss of lock (1..`WIN_LEN`).

Ports:
- `clk_mar` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bit_in` in 1: received hard-decision bit.
- `bit_valid` in 1: one-cycle strobe; `bit_in` is sampled only when high.
- `lock` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse per errored bit while LOCKED.
- `err_snap` out 16: error count of the last completed window.
- `win_done` out 1: one-cycle pulse when `err_snap` updates.

## Operation
- Recurrence. The generator's output stream satisfies `b[t] = b[t-1] XOR b[t-4]`. Reference stream from seed 0001: `1000 1111 0101 100`, repeating every 15 bits.
- History register `h[3:0]` holds the last 4 bits (`h[0]` newest). Prediction `p = h[0] XOR h[3]`.
- States:
  - FILL: reset state. Shift `bit_in` into `h` on each `bit_valid`. After 4 bits, go to ACQ.
  - ACQ: on each `bit_valid`, compare `bit_in` with `p`.
    - Match and `h != 0`: increment `run`.
    - Mismatch, or `h == 0`: clear `run`. The all-zero guard stops a stuck-at-0 line from locking.
    - `h` shifts in `bit_in` (received bits).
    - When `run` reaches `LOCK_CNT`, go to LOCKED. Clear the window counters on that same edge.
  - LOCKED: `h` shifts in `p` (free-running local LFSR; received bits are not fed back).
    - On each `bit_valid`: `bit_in != p` → `err_pulse` and increment `werr`.
    - `werr` saturates at 16'hFFFF.
  - Loss: if `werr` reaches `LOSS_THR` in LOCKED, go to ACQ with `run` = 0.
    - `h` keeps its local value and re-seeds from received bits over the next 4 bits.
    - The window in progress is abandoned; `err_snap` is not updated.
- Window: `wbits` counts `bit_valid` events in LOCKED. On the `WIN_LEN`-th bit:
  - `err_snap` ← `werr` plus this bit's error.
  - `win_done` pulses.
  - `wbits` and `werr` clear.
- Loss and window end on the same bit: the window end is applied (snapshot taken, `win_done` pulses), then the state goes to ACQ.
- `bit_valid` low: no state change anywhere.

## Timing
- Reset values:
  - Outputs: `lock` = 0, `err_pulse` = 0, `err_snap` = 0, `win_done` = 0.
  - Internal: state = FILL, `h` = 0, `run` = 0, `wbits` = 0, `werr` = 0.
- All outputs are registered.
- `err_pulse` and `win_done` assert in the cycle after the sampled `bit_valid`, for exactly one cycle.
- `lock` rises in the cycle after the `bit_valid` that completes `LOCK_CNT`. It falls in the cycle after the `bit_valid` that hits `LOSS_THR`.
- Minimum lock time on a clean stream: 4 + `LOCK_CNT` valid bits.
- Back-to-back `bit_valid` (every cycle) is supported.
- `rst` mid-operation returns the block to FILL immediately, asynchronously.

## Structure
- Shared package `m_pkg` holds:
  - state enum: FILL, ACQ, LOCKED
  - constant `M_TAPS` = 4'b1001, the XOR taps of the recurrence
  - `M_PERIOD` = 15
- One sub-module `m_pred`. It contains the 4-bit history, prediction, and a shift-source select (received vs predicted). The top level contains the FSM, `run`, and the window/error counters.

## Test plan
- Clean stream, `bit_valid` every cycle, `LOCK_CNT` = 16: `lock` high in the cycle after bit 20; zero `err_pulse`; `err_snap` = 0 at each `win_done`.
- Locked, invert bits 100, 200 and 300 after lock: exactly 3 `err_pulse`s; next `err_snap` = 3.
- Constant 0 input: `lock` never asserts; `run` stays 0.
- Locked, then a burst of 40 inverted bits, `LOSS_THR` = 32: `lock` drops after the 32nd error. A clean stream afterwards relocks after 4 + 16 bits.
- `bit_valid` every 3rd cycle on a clean stream: same lock bit count as the first scenario; no pulses on idle cycles.
- `rst` asserted mid-window while LOCKED: `lock`, `err_snap` and `win_done` go to 0 at once. After release the block re-runs FILL and needs 20 bits to relock.
